// File: rtl/dht11_responder.sv
// DHT11 sensor-side emulator: answers a host start pulse on an open-drain line with
// the response preamble and a 40-bit frame {hum_int, hum_float, temp_int, temp_float, checksum}.
module dht11_responder #(
  parameter int unsigned CYCLES_PER_US = 50,
  parameter int unsigned START_MIN_US  = 18000,
  parameter int unsigned RESP_DELAY_US = 30,
  parameter int unsigned RESP_LOW_US   = 80,
  parameter int unsigned RESP_HIGH_US  = 80,
  parameter int unsigned BIT_LOW_US    = 50,
  parameter int unsigned BIT0_HIGH_US  = 26,
  parameter int unsigned BIT1_HIGH_US  = 70
) (
  input  logic       clock,
  input  logic       reset,
  inout  wire        transmission_line,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_float,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_float,
  input  logic       inject_error,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    HOST_LOW   = 3'd1,
    RESP_DELAY = 3'd2,
    RESP_LOW   = 3'd3,
    RESP_HIGH  = 3'd4,
    BIT_LOW    = 3'd5,
    BIT_HIGH   = 3'd6,
    STOP_LOW   = 3'd7
  } state_t;

  // Down-counter reload values: a phase of N us lasts exactly N*CYCLES_PER_US cycles.
  localparam logic [19:0] START_CYC     = 20'(START_MIN_US * CYCLES_PER_US);
  localparam logic [19:0] LD_RESP_DELAY = 20'(RESP_DELAY_US * CYCLES_PER_US - 1);
  localparam logic [19:0] LD_RESP_LOW   = 20'(RESP_LOW_US * CYCLES_PER_US - 1);
  localparam logic [19:0] LD_RESP_HIGH  = 20'(RESP_HIGH_US * CYCLES_PER_US - 1);
  localparam logic [19:0] LD_BIT_LOW    = 20'(BIT_LOW_US * CYCLES_PER_US - 1);
  localparam logic [19:0] LD_BIT0_HIGH  = 20'(BIT0_HIGH_US * CYCLES_PER_US - 1);
  localparam logic [19:0] LD_BIT1_HIGH  = 20'(BIT1_HIGH_US * CYCLES_PER_US - 1);
  localparam logic [19:0] LOW_MAX       = 20'hF_FFFF;

  function automatic logic [7:0] frame_checksum(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c, input logic [7:0] d);
    return a + b + c + d;
  endfunction

  state_t      state_r, state_s;
  logic [1:0]  sync_r;
  logic        sl_s;
  logic [19:0] cnt_r, cnt_s;
  logic [19:0] low_r, low_s;
  logic [5:0]  idx_r, idx_s;
  logic [39:0] frame_r, frame_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        drive_r, drive_s;
  logic        tick_s;

  assign sl_s              = sync_r[1];
  assign tick_s            = (cnt_r == 20'd0);
  assign busy              = busy_r;
  assign frame_done        = done_r;
  assign transmission_line = drive_r ? 1'b0 : 1'bz;

  // Two-flop synchronizer for the shared line; idles high like the pulled-up wire.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], transmission_line};
    end
  end

  // State, timers, frame shifter and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= 20'd0;
      low_r   <= 20'd0;
      idx_r   <= 6'd0;
      frame_r <= 40'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      drive_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      low_r   <= low_s;
      idx_r   <= idx_s;
      frame_r <= frame_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      drive_r <= drive_s;
    end
  end

  // Next-state logic; sl is only consulted in IDLE and HOST_LOW so a frame cannot be aborted.
  always_comb begin
    state_s = state_r;
    cnt_s   = tick_s ? cnt_r : cnt_r - 20'd1;
    low_s   = low_r;
    idx_s   = idx_r;
    frame_s = frame_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s  = 20'd0;
        busy_s = 1'b0;
        if (!sl_s) begin
          state_s = HOST_LOW;
          low_s   = 20'd1;
        end else begin
          low_s = 20'd0;
        end
      end
      HOST_LOW: begin
        if (!sl_s) begin
          low_s = (low_r == LOW_MAX) ? low_r : low_r + 20'd1;
        end else if (low_r >= START_CYC) begin
          state_s = RESP_DELAY;
          cnt_s   = LD_RESP_DELAY;
          busy_s  = 1'b1;
          frame_s = {hum_int, hum_float, temp_int, temp_float,
                     frame_checksum(hum_int, hum_float, temp_int, temp_float)
                       ^ {7'd0, inject_error}};
        end else begin
          state_s = IDLE;
        end
      end
      RESP_DELAY: begin
        if (tick_s) begin
          state_s = RESP_LOW;
          cnt_s   = LD_RESP_LOW;
        end else begin
          state_s = RESP_DELAY;
        end
      end
      RESP_LOW: begin
        if (tick_s) begin
          state_s = RESP_HIGH;
          cnt_s   = LD_RESP_HIGH;
        end else begin
          state_s = RESP_LOW;
        end
      end
      RESP_HIGH: begin
        if (tick_s) begin
          state_s = BIT_LOW;
          cnt_s   = LD_BIT_LOW;
          idx_s   = 6'd39;
        end else begin
          state_s = RESP_HIGH;
        end
      end
      BIT_LOW: begin
        if (tick_s) begin
          state_s = BIT_HIGH;
          cnt_s   = frame_r[39] ? LD_BIT1_HIGH : LD_BIT0_HIGH;
        end else begin
          state_s = BIT_LOW;
        end
      end
      BIT_HIGH: begin
        if (tick_s) begin
          frame_s = {frame_r[38:0], 1'b0};
          cnt_s   = LD_BIT_LOW;
          if (idx_r != 6'd0) begin
            state_s = BIT_LOW;
            idx_s   = idx_r - 6'd1;
          end else begin
            state_s = STOP_LOW;
          end
        end else begin
          state_s = BIT_HIGH;
        end
      end
      STOP_LOW: begin
        if (tick_s) begin
          state_s = IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          state_s = STOP_LOW;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // The line is pulled low only in the three DUT-driven low phases.
  always_comb begin
    drive_s = (state_s == RESP_LOW) || (state_s == BIT_LOW) || (state_s == STOP_LOW);
  end

endmodule
